// File: rtl/uart_rx_axis.sv
// Oversampling UART receiver with an AXI4-Stream master output through a 1-deep holding register.
// Optional parity checking is enabled by defining UART_PARITY_EN.
module uart_rx_axis #(
   parameter int DBIT    = 8,
   parameter int OS      = 16,
   parameter int SB_TICK = 16,
   parameter int PAR_ODD = 0
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            btick,
   input  logic            rx,
   output logic [DBIT-1:0] m_axis_tdata,
   output logic            m_axis_tvalid,
   input  logic            m_axis_tready,
   output logic            frame_err,
   output logic            overrun,
   output logic            parity_err
);

   localparam int CMAX = (OS > SB_TICK) ? OS : SB_TICK;
   localparam int CW   = $clog2(CMAX);
   localparam int NW   = (DBIT > 1) ? $clog2(DBIT) : 1;

   localparam logic [CW-1:0] S_HALF = CW'(OS / 2 - 1);
   localparam logic [CW-1:0] S_BIT  = CW'(OS - 1);
   localparam logic [CW-1:0] S_STOP = CW'(SB_TICK - 1);
   localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);

`ifdef UART_PARITY_EN
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } state_t;
`else
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } state_t;
`endif

   logic [1:0]      r_sync;
   state_t          r_state;
   logic [CW-1:0]   r_s_cnt;
   logic [NW-1:0]   r_n_cnt;
   logic [DBIT-1:0] r_shreg;
   logic [DBIT-1:0] r_tdata;
   logic            r_tvalid;
   logic            r_frame_err;
   logic            r_overrun;
   logic            r_parity_err;

   logic            w_rx_s;
   state_t          w_state_n;
   logic [CW-1:0]   w_s_cnt_n;
   logic [NW-1:0]   w_n_cnt_n;
   logic [DBIT-1:0] w_shreg_n;
   logic            w_done;
   logic            w_par_flag;
   logic            w_deliver;
   logic            w_load;
   logic            w_tvalid_n;
   logic [DBIT-1:0] w_tdata_n;

`ifdef UART_PARITY_EN
   logic            r_par_bad;
   logic            w_par_bad_n;
   assign w_par_flag = r_par_bad;
`else
   assign w_par_flag = 1'b0;
`endif

   assign w_rx_s = r_sync[1];

   // State, counters, synchroniser and output registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_sync       <= 2'b11;
         r_state      <= ST_IDLE;
         r_s_cnt      <= '0;
         r_n_cnt      <= '0;
         r_shreg      <= '0;
         r_tdata      <= '0;
         r_tvalid     <= 1'b0;
         r_frame_err  <= 1'b0;
         r_overrun    <= 1'b0;
         r_parity_err <= 1'b0;
`ifdef UART_PARITY_EN
         r_par_bad    <= 1'b0;
`endif
      end else begin
         r_sync       <= {r_sync[0], rx};
         r_state      <= w_state_n;
         r_s_cnt      <= w_s_cnt_n;
         r_n_cnt      <= w_n_cnt_n;
         r_shreg      <= w_shreg_n;
         r_tdata      <= w_tdata_n;
         r_tvalid     <= w_tvalid_n;
         r_frame_err  <= w_done & ~w_rx_s;
         r_overrun    <= w_deliver & r_tvalid & ~m_axis_tready;
`ifdef UART_PARITY_EN
         r_parity_err <= w_done & w_rx_s & r_par_bad;
         r_par_bad    <= w_par_bad_n;
`else
         r_parity_err <= 1'b0;
`endif
      end
   end

   // Receive FSM next-state: all timing advances only on btick
   always_comb begin
      w_state_n = r_state;
      w_s_cnt_n = r_s_cnt;
      w_n_cnt_n = r_n_cnt;
      w_shreg_n = r_shreg;
      w_done    = 1'b0;
`ifdef UART_PARITY_EN
      w_par_bad_n = r_par_bad;
`endif
      case (r_state)
         ST_IDLE: begin
            if (!w_rx_s) begin
               w_state_n = ST_START;
               w_s_cnt_n = '0;
            end else begin
               w_state_n = ST_IDLE;
            end
         end
         ST_START: begin
            if (btick) begin
               if (r_s_cnt == S_HALF) begin
                  if (!w_rx_s) begin
                     w_state_n = ST_DATA;
                     w_s_cnt_n = '0;
                     w_n_cnt_n = '0;
`ifdef UART_PARITY_EN
                     w_par_bad_n = 1'b0;
`endif
                  end else begin
                     w_state_n = ST_IDLE;
                  end
               end else begin
                  w_s_cnt_n = r_s_cnt + CW'(1);
               end
            end else begin
               w_s_cnt_n = r_s_cnt;
            end
         end
         ST_DATA: begin
            if (btick) begin
               if (r_s_cnt == S_BIT) begin
                  w_shreg_n = {w_rx_s, r_shreg[DBIT-1:1]};
                  w_s_cnt_n = '0;
                  if (r_n_cnt == N_LAST) begin
`ifdef UART_PARITY_EN
                     w_state_n = ST_PARITY;
`else
                     w_state_n = ST_STOP;
`endif
                  end else begin
                     w_n_cnt_n = r_n_cnt + NW'(1);
                  end
               end else begin
                  w_s_cnt_n = r_s_cnt + CW'(1);
               end
            end else begin
               w_s_cnt_n = r_s_cnt;
            end
         end
`ifdef UART_PARITY_EN
         ST_PARITY: begin
            if (btick) begin
               if (r_s_cnt == S_BIT) begin
                  w_par_bad_n = ((^{r_shreg, w_rx_s}) != (PAR_ODD != 0));
                  w_s_cnt_n   = '0;
                  w_state_n   = ST_STOP;
               end else begin
                  w_s_cnt_n = r_s_cnt + CW'(1);
               end
            end else begin
               w_s_cnt_n = r_s_cnt;
            end
         end
`endif
         ST_STOP: begin
            if (btick) begin
               if (r_s_cnt == S_STOP) begin
                  w_state_n = ST_IDLE;
                  w_s_cnt_n = '0;
                  w_done    = 1'b1;
               end else begin
                  w_s_cnt_n = r_s_cnt + CW'(1);
               end
            end else begin
               w_s_cnt_n = r_s_cnt;
            end
         end
         default: begin
            w_state_n = ST_IDLE;
            w_s_cnt_n = '0;
            w_n_cnt_n = '0;
         end
      endcase
   end

   // Holding register: a completing frame loads only if the slot is free or being emptied
   always_comb begin
      w_deliver  = w_done & w_rx_s & ~w_par_flag;
      w_load     = w_deliver & (~r_tvalid | m_axis_tready);
      w_tvalid_n = r_tvalid;
      w_tdata_n  = r_tdata;
      if (w_load) begin
         w_tvalid_n = 1'b1;
         w_tdata_n  = r_shreg;
      end else if (r_tvalid && m_axis_tready) begin
         w_tvalid_n = 1'b0;
      end else begin
         w_tvalid_n = r_tvalid;
      end
   end

   assign m_axis_tdata  = r_tdata;
   assign m_axis_tvalid = r_tvalid;
   assign frame_err     = r_frame_err;
   assign overrun       = r_overrun;
   assign parity_err    = r_parity_err;

endmodule

// File: tb/tb_uart_rx_axis.sv
// Directed testbench for uart_rx_axis: scoreboard of expected words and error-pulse counts.
// Parity scenarios run when UART_PARITY_EN is defined.
module tb_uart_rx_axis;

   localparam int DBIT    = 8;
   localparam int OS      = 16;
   localparam int SB_TICK = 16;
   localparam int BIT_CLK = OS * 4;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            btick = 1'b0;
   logic            rx = 1'b1;
   logic            tready = 1'b1;
   logic [DBIT-1:0] tdata;
   logic            tvalid;
   logic            frame_err;
   logic            overrun;
   logic            parity_err;

   uart_rx_axis #(.DBIT(DBIT), .OS(OS), .SB_TICK(SB_TICK), .PAR_ODD(0)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .btick         (btick),
      .rx            (rx),
      .m_axis_tdata  (tdata),
      .m_axis_tvalid (tvalid),
      .m_axis_tready (tready),
      .frame_err     (frame_err),
      .overrun       (overrun),
      .parity_err    (parity_err)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_bad = 0;

   logic [7:0] exp_q[$];
   int fe_cnt = 0, ov_cnt = 0, pe_cnt = 0;
   int exp_fe = 0, exp_ov = 0, exp_pe = 0;
   logic [7:0] last_pop = 8'h00;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   // btick every 4th clock
   initial begin
      int c = 0;
      forever begin
         @(negedge clk);
         btick = (c == 3);
         c = (c + 1) % 4;
      end
   end

   // Per-cycle monitor against the scoreboard
   initial begin
      logic p_valid = 1'b0;
      logic [7:0] p_data = 8'h00;
      logic p_fe = 1'b0, p_ov = 1'b0, p_pe = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (rst_n) begin
            if (p_valid && tready) begin
               chk("hs_queue", exp_q.size() != 0, 1'b1);
               if (exp_q.size() != 0) begin
                  chk("hs_data", p_data, exp_q[0]);
                  last_pop = exp_q.pop_front();
               end
            end
            if (p_valid && !tready) begin
               chk("hold_valid", tvalid, 1'b1);
               chk("hold_data", tdata, p_data);
            end
            if (tvalid) begin
               chk("valid_expected", exp_q.size() != 0, 1'b1);
               if (exp_q.size() != 0) chk("tdata", tdata, exp_q[0]);
            end
            if (frame_err) begin
               fe_cnt++;
               chk("fe_width", p_fe, 1'b0);
            end
            if (overrun) begin
               ov_cnt++;
               chk("ov_width", p_ov, 1'b0);
            end
            if (parity_err) begin
               pe_cnt++;
               chk("pe_width", p_pe, 1'b0);
            end
         end
         p_valid = tvalid;
         p_data  = tdata;
         p_fe    = frame_err;
         p_ov    = overrun;
         p_pe    = parity_err;
      end
   end

   // par_bit: -1 sends correct even parity, 0/1 forces the bit (parity builds only)
   task automatic send_frame(input logic [7:0] d, input logic stop_v, input int par_bit,
                             input int abort_at);
      rx = 1'b0;
      wait_clk(BIT_CLK);
      for (int i = 0; i < DBIT; i++) begin
         rx = d[i];
         if (i == abort_at) begin
            wait_clk(BIT_CLK / 2);
            rst_n = 1'b0;
            rx    = 1'b1;
            wait_clk(1);
            rst_n = 1'b1;
            return;
         end
         wait_clk(BIT_CLK);
      end
`ifdef UART_PARITY_EN
      rx = (par_bit < 0) ? ^d : par_bit[0];
      wait_clk(BIT_CLK);
`else
      if (par_bit > 1) rx = 1'b1;
`endif
      rx = stop_v;
      // a short low stop bit keeps the following false start from surviving its mid check
      wait_clk(stop_v ? BIT_CLK : 40);
      rx = 1'b1;
      wait_clk(2 * BIT_CLK);
   endtask

   task automatic chk_counts(input string tag);
      chk({tag, "_fe"}, fe_cnt, exp_fe);
      chk({tag, "_ov"}, ov_cnt, exp_ov);
      chk({tag, "_pe"}, pe_cnt, exp_pe);
   endtask

   initial begin
      wait_clk(3);
      chk("rst_tvalid", tvalid, 1'b0);
      chk("rst_tdata", tdata, 8'h00);
      chk("rst_errs", {frame_err, overrun, parity_err}, 3'b000);
      rst_n = 1'b1;
      wait_clk(2 * BIT_CLK);

      // 1: plain frame
      exp_q.push_back(8'hA5);
      send_frame(8'hA5, 1'b1, -1, -1);
      chk("t1_word", last_pop, 8'hA5);
      chk("t1_q", exp_q.size(), 0);
      chk_counts("t1");

      // 2: start glitch of 5 bticks
      rx = 1'b0;
      wait_clk(5 * 4);
      rx = 1'b1;
      wait_clk(2 * BIT_CLK);
      chk("t2_tvalid", tvalid, 1'b0);
      chk_counts("t2");

      // 3: framing error
      exp_fe++;
      send_frame(8'h3C, 1'b0, -1, -1);
      chk("t3_tvalid", tvalid, 1'b0);
      chk_counts("t3");

      // 4: overrun while stalled
      tready = 1'b0;
      exp_q.push_back(8'h11);
      send_frame(8'h11, 1'b1, -1, -1);
      exp_ov++;
      send_frame(8'h22, 1'b1, -1, -1);
      chk("t4_tvalid", tvalid, 1'b1);
      chk("t4_tdata", tdata, 8'h11);
      chk_counts("t4");
      tready = 1'b1;
      wait_clk(1);
      chk("t4_drain", tvalid, 1'b0);
      chk("t4_word", last_pop, 8'h11);

      // 5: reset during data bit 4
      send_frame(8'h00, 1'b1, -1, 4);
      chk("t5_rst_tvalid", tvalid, 1'b0);
      wait_clk(2 * BIT_CLK);
      exp_q.push_back(8'h5A);
      send_frame(8'h5A, 1'b1, -1, -1);
      chk("t5_word", last_pop, 8'h5A);
      chk_counts("t5");

`ifdef UART_PARITY_EN
      // 6: parity good then bad
      exp_q.push_back(8'h07);
      send_frame(8'h07, 1'b1, 1, -1);
      chk("t6_word", last_pop, 8'h07);
      exp_pe++;
      send_frame(8'h07, 1'b1, 0, -1);
      chk("t6_tvalid", tvalid, 1'b0);
      chk_counts("t6");
`endif

      chk("end_q", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
